// File: rtl/gg_mb_sequencer.sv
// Purpose : macroblock sequencer; steps the gg_process 4x4 datapath through
//           every block of a macroblock in H.264 coding order and totals results.
// Latency : start -> first blk_valid 1 cycle; last accepted block -> done 1 cycle.
// Backpr. : blk_ready low holds step, cidx/bidx and the totals; start is
//           ignored outside IDLE (no queueing).
// Ports   : start/i16/qpy_in/*_oop_in  macroblock controls, latched at start
//           cidx/bidx/qpy/*_out_of_pic  datapath controls for the current block
//           blk_valid/blk_ready/first/last  per-block handshake to the writer
//           bitcount/ssd/overflow  per-block datapath results
//           busy/done/mb_*  macroblock status and saturating totals
module gg_mb_sequencer #(
  parameter int BC_W   = 9,
  parameter int SSD_W  = 20,
  parameter int MBC_W  = 15,
  parameter int MSSD_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              i16,
  input  logic [5:0]        qpy_in,
  input  logic              abv_oop_in,
  input  logic              left_oop_in,
  output logic [2:0]        cidx,
  output logic [3:0]        bidx,
  output logic [5:0]        qpy,
  output logic              abv_out_of_pic,
  output logic              left_out_of_pic,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_first,
  output logic              blk_last,
  input  logic [BC_W-1:0]   bitcount,
  input  logic [SSD_W-1:0]  ssd,
  input  logic [6:0]        overflow,
  output logic              busy,
  output logic              done,
  output logic [MBC_W-1:0]  mb_bitcount,
  output logic [MSSD_W-1:0] mb_ssd,
  output logic [6:0]        mb_overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] step, step_nxt;
  logic       mode_i16;
  logic       xfer;
  logic       at_last;

  logic [MBC_W:0]    bc_sum;
  logic [MSSD_W:0]   ssd_sum;
  logic [MBC_W-1:0]  bc_sat;
  logic [MSSD_W-1:0] ssd_sat;

  // Step -> {cidx, bidx}. i16 mode inserts the luma DC block at step 16 and
  // shifts the chroma part of the 4x4 table by one.
  function automatic logic [6:0] decode(input logic [4:0] s, input logic m);
    logic [4:0] c;
    logic [4:0] off;
    c      = '0;
    off    = '0;
    decode = '0;
    if (s < 5'd16) begin
      decode = {(m ? 3'd1 : 3'd0), s[3:0]};
    end else if (m && s == 5'd16) begin
      decode = {3'd6, 4'd0};
    end else begin
      c = m ? s - 5'd1 : s;
      if (c == 5'd16) begin
        decode = {3'd4, 4'd0};
      end else if (c == 5'd17) begin
        decode = {3'd5, 4'd0};
      end else if (c < 5'd22) begin
        off    = c - 5'd18;
        decode = {3'd2, off[3:0]};
      end else begin
        off    = c - 5'd22;
        decode = {3'd3, off[3:0]};
      end
    end
  endfunction

  assign xfer      = (state == RUN) && blk_ready;
  assign at_last   = (step == (mode_i16 ? 5'd26 : 5'd25));
  assign blk_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign blk_first = (state == RUN) && (step == 5'd0);
  assign blk_last  = (state == RUN) && at_last;

  // One extra carry bit per accumulator; a carry out pins the total at all-ones.
  assign bc_sum  = {1'b0, mb_bitcount} + {{(MBC_W + 1 - BC_W){1'b0}}, bitcount};
  assign ssd_sum = {1'b0, mb_ssd} + {{(MSSD_W + 1 - SSD_W){1'b0}}, ssd};
  assign bc_sat  = bc_sum[MBC_W]   ? '1 : bc_sum[MBC_W-1:0];
  assign ssd_sat = ssd_sum[MSSD_W] ? '1 : ssd_sum[MSSD_W-1:0];

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          step_nxt  = 5'd0;
        end
      end
      RUN: begin
        if (blk_ready) begin
          if (at_last) state_nxt = DONE;
          else         step_nxt  = step + 5'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      step            <= '0;
      mode_i16        <= 1'b0;
      qpy             <= '0;
      abv_out_of_pic  <= 1'b0;
      left_out_of_pic <= 1'b0;
      cidx            <= '0;
      bidx            <= '0;
      mb_bitcount     <= '0;
      mb_ssd          <= '0;
      mb_overflow     <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (state == IDLE && start) begin
        mode_i16        <= i16;
        qpy             <= qpy_in;
        abv_out_of_pic  <= abv_oop_in;
        left_out_of_pic <= left_oop_in;
        {cidx, bidx}    <= decode(5'd0, i16);
        mb_bitcount     <= '0;
        mb_ssd          <= '0;
        mb_overflow     <= '0;
      end
      if (xfer) begin
        mb_bitcount <= bc_sat;
        mb_ssd      <= ssd_sat;
        mb_overflow <= mb_overflow | overflow;
        // cidx/bidx are decoded a cycle ahead so they are already registered
        // when the new step is presented.
        if (!at_last) {cidx, bidx} <= decode(step + 5'd1, mode_i16);
      end
    end
  end

endmodule

// File: tb/tb_gg_mb_sequencer.sv
// Purpose : self-checking bench for gg_mb_sequencer; a queue-based macroblock
//           model is compared against the DUT every falling edge.
// Latency : n/a (bench).
// Backpr. : blk_ready driven from per-test 4-cycle patterns.
module tb_gg_mb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        i16;
  logic [5:0]  qpy_in;
  logic        abv_oop_in;
  logic        left_oop_in;
  logic [2:0]  cidx;
  logic [3:0]  bidx;
  logic [5:0]  qpy;
  logic        abv_out_of_pic;
  logic        left_out_of_pic;
  logic        blk_valid;
  logic        blk_ready;
  logic        blk_first;
  logic        blk_last;
  logic [8:0]  bitcount;
  logic [19:0] ssd;
  logic [6:0]  overflow;
  logic        busy;
  logic        done;
  logic [14:0] mb_bitcount;
  logic [24:0] mb_ssd;
  logic [6:0]  mb_overflow;

  int n_vec = 0;
  int n_err = 0;

  // Datapath stub controls
  logic dp_var = 1'b0;
  logic ov_en  = 1'b0;

  gg_mb_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .i16(i16), .qpy_in(qpy_in),
    .abv_oop_in(abv_oop_in), .left_oop_in(left_oop_in),
    .cidx(cidx), .bidx(bidx), .qpy(qpy),
    .abv_out_of_pic(abv_out_of_pic), .left_out_of_pic(left_out_of_pic),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last),
    .bitcount(bitcount), .ssd(ssd), .overflow(overflow),
    .busy(busy), .done(done),
    .mb_bitcount(mb_bitcount), .mb_ssd(mb_ssd), .mb_overflow(mb_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dp_bc(input logic [2:0] c, input logic [3:0] b);
    return int'(c) * 16 + int'(b) + 1;
  endfunction

  // Datapath stub: results are combinational on cidx/bidx.
  always_comb begin
    bitcount = dp_var ? 9'(dp_bc(cidx, bidx)) : 9'd10;
    ssd      = 20'd100;
    overflow = (ov_en && blk_valid && cidx == 3'd0 && bidx == 4'd5) ? 7'h04 : 7'h00;
  end

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 running, 2 done-cycle
  int         m_st = 0;
  int         m_step = 0;
  int         m_bc = 0;
  int         m_ssd = 0;
  logic [6:0] m_ov = '0;
  logic [5:0] m_qp = '0;
  logic       m_abv = 1'b0;
  logic       m_left = 1'b0;
  logic [6:0] tbl[$];
  logic [6:0] m_e;

  // Coding order as a list of {cidx, bidx}.
  task automatic build_tbl(input logic mode);
    tbl.delete();
    for (int i = 0; i < 16; i++) tbl.push_back({(mode ? 3'd1 : 3'd0), 4'(i)});
    if (mode) tbl.push_back({3'd6, 4'd0});
    tbl.push_back({3'd4, 4'd0});
    tbl.push_back({3'd5, 4'd0});
    for (int i = 0; i < 4; i++) tbl.push_back({3'd2, 4'(i)});
    for (int i = 0; i < 4; i++) tbl.push_back({3'd3, 4'(i)});
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_st = 0; m_step = 0; m_bc = 0; m_ssd = 0; m_ov = '0;
      m_qp = '0; m_abv = 1'b0; m_left = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", blk_valid, 0);
      chk("rst_cidx", cidx, 0);
      chk("rst_bidx", bidx, 0);
      chk("rst_mb_bitcount", mb_bitcount, 0);
    end else begin
      chk("busy", busy, m_st != 0);
      chk("done", done, m_st == 2);
      chk("blk_valid", blk_valid, m_st == 1);
      chk("blk_first", blk_first, (m_st == 1) && (m_step == 0));
      chk("blk_last", blk_last, (m_st == 1) && (m_step == tbl.size() - 1));
      chk("qpy", qpy, m_qp);
      chk("abv_oop", abv_out_of_pic, m_abv);
      chk("left_oop", left_out_of_pic, m_left);
      chk("mb_bitcount", mb_bitcount, m_bc);
      chk("mb_ssd", mb_ssd, m_ssd);
      chk("mb_overflow", mb_overflow, m_ov);
      if (m_st == 1) begin
        m_e = tbl[m_step];
        chk("cidx", cidx, m_e[6:4]);
        chk("bidx", bidx, m_e[3:0]);
      end
      case (m_st)
        0: if (start) begin
          build_tbl(i16);
          m_qp = qpy_in; m_abv = abv_oop_in; m_left = left_oop_in;
          m_bc = 0; m_ssd = 0; m_ov = '0; m_step = 0; m_st = 1;
        end
        1: if (blk_ready) begin
          m_e  = tbl[m_step];
          m_bc = m_bc + (dp_var ? dp_bc(m_e[6:4], m_e[3:0]) : 10);
          if (m_bc > 32767) m_bc = 32767;
          m_ssd = m_ssd + 100;
          if (m_ssd > 33554431) m_ssd = 33554431;
          if (ov_en && m_e == {3'd0, 4'd5}) m_ov = m_ov | 7'h04;
          if (m_step == tbl.size() - 1) m_st = 2;
          else m_step++;
        end
        default: m_st = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  // Pulses start until accepted, then runs the macroblock until done shows.
  // Controls are flipped after acceptance to prove they were latched.
  task automatic run_mb(input logic mi16, input logic [5:0] qp, input logic abv,
                        input logic lft, input logic [3:0] pat,
                        input logic mid_start, output int nv);
    int cyc;
    int k;
    i16 = mi16; qpy_in = qp; abv_oop_in = abv; left_oop_in = lft;
    start = 1'b1; blk_ready = pat[0];
    nv = 0; cyc = 0; k = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!busy && cyc < 10);
    start = 1'b0;
    i16 = ~mi16; qpy_in = ~qp; abv_oop_in = ~abv; left_oop_in = ~lft;
    while (!done && cyc < 400) begin
      if (blk_valid) nv++;
      blk_ready = pat[k % 4];
      k++;
      start = mid_start && (cyc == 6);
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    chk("mb_done_seen", done, 1);
  endtask

  initial begin
    int nv;
    int cyc;
    reset = 1'b1; start = 1'b0; i16 = 1'b0; qpy_in = '0;
    abv_oop_in = 1'b0; left_oop_in = 1'b0; blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_qpy", qpy, 0);
    chk("init_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4x4 macroblock, always ready
    run_mb(1'b0, 6'd29, 1'b1, 1'b0, 4'b1111, 1'b0, nv);
    chk("t1_valid_cycles", nv, 26);
    chk("t1_mb_bitcount", mb_bitcount, 260);
    chk("t1_mb_ssd", mb_ssd, 2600);
    chk("t1_qpy", qpy, 29);
    chk("t1_abv", abv_out_of_pic, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_hold_bitcount", mb_bitcount, 260);

    // Intra16x16 macroblock
    run_mb(1'b1, 6'd17, 1'b0, 1'b1, 4'b1111, 1'b0, nv);
    chk("t2_valid_cycles", nv, 27);
    chk("t2_mb_bitcount", mb_bitcount, 270);
    chk("t2_mb_ssd", mb_ssd, 2700);
    chk("t2_left", left_out_of_pic, 1);
    repeat (2) @(posedge clk);
    #1;

    // Stalls (ready 1,0,0,1), block-dependent bitcount, overflow on step 5
    dp_var = 1'b1; ov_en = 1'b1;
    run_mb(1'b0, 6'd5, 1'b0, 1'b0, 4'b1001, 1'b0, nv);
    chk("t3_mb_bitcount", mb_bitcount, 622);
    chk("t3_mb_ssd", mb_ssd, 2600);
    chk("t3_mb_overflow", mb_overflow, 7'h04);
    chk("t3_stall_cycles_gt", nv > 26, 1);
    dp_var = 1'b0; ov_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Start re-pulsed in RUN, then in DONE (ignored), accepted the cycle after
    run_mb(1'b0, 6'd40, 1'b0, 1'b0, 4'b1111, 1'b1, nv);
    chk("t4a_valid_cycles", nv, 26);
    chk("t4a_mb_bitcount", mb_bitcount, 260);
    run_mb(1'b1, 6'd41, 1'b1, 1'b1, 4'b1111, 1'b0, nv);
    chk("t4b_valid_cycles", nv, 27);
    chk("t4b_mb_bitcount", mb_bitcount, 270);
    chk("t4b_qpy", qpy, 41);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset at step 12
    i16 = 1'b0; qpy_in = 6'd33; blk_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(blk_valid && cidx == 3'd0 && bidx == 4'd12) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("t5_reach_step12", blk_valid && bidx == 4'd12, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_arst_busy", busy, 0);
    chk("t5_arst_valid", blk_valid, 0);
    chk("t5_arst_bidx", bidx, 0);
    chk("t5_arst_qpy", qpy, 0);
    chk("t5_arst_mb_bitcount", mb_bitcount, 0);
    chk("t5_arst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_mb(1'b0, 6'd12, 1'b0, 1'b0, 4'b1111, 1'b0, nv);
    chk("t5_after_valid_cycles", nv, 26);
    chk("t5_after_mb_bitcount", mb_bitcount, 260);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
